// File: rtl/scan_frame_tx_if.sv
// Request handshake bundle for scan_frame_tx: valid/ready plus write payload.
interface scan_frame_tx_if #(
  parameter int W = 4,
  parameter int K = 5
) ();
  logic         req_valid;
  logic         req_ready;
  logic         req_wr;
  logic [K-1:0] req_addr;
  logic [W-1:0] req_data;

  modport master (output req_valid, req_wr, req_addr, req_data, input req_ready);
  modport slave  (input req_valid, req_wr, req_addr, req_data, output req_ready);
endinterface

// File: rtl/scan_frame_tx.sv
// scan_frame_tx: serialises memory-write requests MSB-first for a scan-in
// shift-register loader. Frame order is data, addr, wr so the far-end register
// ends up holding {data, addr, wr}. Each bit is held DIV cycles and every frame
// is followed by GAP idle zero cycles.
// Build option: define SCAN_FRAME_TX_PARITY_EN to prepend an even-parity bit
// over {data, addr, wr}, landing above data in the receiver.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for request; req_ready high, scan_out low
// S_SHIFT | frame bits on scan_out, scan_frame high
// S_GAP   | GAP idle zero cycles after the frame; frame_done in first
module scan_frame_tx #(
  parameter int W   = 4,
  parameter int K   = 5,
  parameter int DIV = 1,
  parameter int GAP = 2
) (
  input  logic           clk,
  input  logic           rst,
  scan_frame_tx_if.slave req,
  output logic           scan_out,
  output logic           scan_frame,
  output logic           frame_done,
  output logic           busy
);

`ifdef SCAN_FRAME_TX_PARITY_EN
  localparam int L = W + K + 2;
`else
  localparam int L = W + K + 1;
`endif
  localparam int              CW       = $clog2(L + 1);
  localparam logic [CW-1:0]   BIT_INIT = CW'(L - 1);
  localparam logic [7:0]      DIV_M1   = 8'(DIV - 1);
  localparam logic [7:0]      GAP_M1   = 8'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t        state_q;
  logic [L-1:0]  sr_q;
  logic [CW-1:0] bit_q;
  logic [7:0]    div_q;
  logic [7:0]    gap_q;
  logic          scan_out_q;
  logic          scan_frame_q;
  logic          frame_done_q;
  logic          busy_q;
  logic [L-1:0]  frame_d;
  logic          accept;

  // Assemble the frame from the live request; only used on the accept edge.
`ifdef SCAN_FRAME_TX_PARITY_EN
  assign frame_d = {^{req.req_data, req.req_addr, req.req_wr},
                    req.req_data, req.req_addr, req.req_wr};
`else
  assign frame_d = {req.req_data, req.req_addr, req.req_wr};
`endif

  assign req.req_ready = (state_q == S_IDLE);
  assign accept        = req.req_valid && (state_q == S_IDLE);

  assign scan_out   = scan_out_q;
  assign scan_frame = scan_frame_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

  // Sequencer: capture, shift with per-bit divider, post-frame gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sr_q         <= '0;
      bit_q        <= '0;
      div_q        <= '0;
      gap_q        <= '0;
      scan_out_q   <= 1'b0;
      scan_frame_q <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q      <= S_SHIFT;
            sr_q         <= frame_d;
            bit_q        <= BIT_INIT;
            div_q        <= DIV_M1;
            scan_out_q   <= frame_d[L-1];
            scan_frame_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (div_q != 8'd0) begin
            div_q <= div_q - 8'd1;
          end else if (bit_q != '0) begin
            sr_q       <= {sr_q[L-2:0], 1'b0};
            bit_q      <= bit_q - CW'(1);
            div_q      <= DIV_M1;
            scan_out_q <= sr_q[L-2];
          end else begin
            scan_out_q   <= 1'b0;
            scan_frame_q <= 1'b0;
            frame_done_q <= 1'b1;
            if (GAP > 0) begin
              state_q <= S_GAP;
              gap_q   <= GAP_M1;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        S_GAP: begin
          if (gap_q == 8'd0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_q <= gap_q - 8'd1;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          scan_out_q   <= 1'b0;
          scan_frame_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

endmodule
